// File: rtl/vga_pkg.sv
// Shared constants, state encoding and helpers for the VGA frame buffer.
package vga_pkg;

    // Stored image geometry
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int FB_DEPTH   = FB_W * FB_H;   // 19200 locations
    localparam int FB_AW      = 15;
    localparam int COL_W      = 12;
    localparam int SCALE_LOG2 = 2;             // each stored pixel is shown 4x4

    // Default 640x480@60 timing, in pixel ticks / lines
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } fb_state_t;

    // Colour word is {R[3:0], G[3:0], B[3:0]}
    function automatic logic [3:0] col_r(input logic [COL_W-1:0] c);
        return c[11:8];
    endfunction

    function automatic logic [3:0] col_g(input logic [COL_W-1:0] c);
        return c[7:4];
    endfunction

    function automatic logic [3:0] col_b(input logic [COL_W-1:0] c);
        return c[3:0];
    endfunction

    // Linear address row*160 + col, with the multiply built from two shifts
    function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_AW-1:0] row,
                                                 input logic [FB_AW-1:0] col);
        return (row << 7) + (row << 5) + col;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old word.
module fb_ram
    import vga_pkg::*;
(
    input  logic             Clock,
    input  logic             we,
    input  logic [FB_AW-1:0] waddr,
    input  logic [COL_W-1:0] wdata,
    input  logic [FB_AW-1:0] raddr,
    output logic [COL_W-1:0] rdata
);

    logic [COL_W-1:0] mem [0:FB_DEPTH-1];

    // Write and registered read share the edge; nonblocking gives old-data read
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_frame_buffer.sv
// 160x120x12 frame buffer accepting plots and scanning out 640x480@60 VGA,
// each stored pixel replicated 4x4. Clears itself to CLEAR_COLOUR after Reset.
module vga_frame_buffer
    import vga_pkg::*;
#(
    parameter logic [COL_W-1:0] CLEAR_COLOUR = 12'h000,
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
)(
    input  logic             Clock,
    input  logic             Reset,
    input  logic [7:0]       x,
    input  logic [6:0]       y,
    input  logic [COL_W-1:0] colour,
    input  logic             writeEn,
    output logic             busy,
    output logic [3:0]       VGA_R,
    output logic [3:0]       VGA_G,
    output logic [3:0]       VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_CLK
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_BEGIN = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    localparam logic [FB_AW-1:0] CLEAR_LAST = FB_AW'(FB_DEPTH - 1);
    localparam logic [7:0]       X_LIMIT    = 8'(FB_W);
    localparam logic [6:0]       Y_LIMIT    = 7'(FB_H);

    // Scan side
    logic             pe;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             vis;
    logic [FB_AW-1:0] rd_addr;
    logic [COL_W-1:0] rd_data;

    logic             hs_p1;
    logic             vs_p1;
    logic             vis_p1;
    logic [COL_W-1:0] pix_p1;
    logic             hs_p2;
    logic             vs_p2;
    logic             vis_p2;
    logic [COL_W-1:0] rgb_p2;

    // Write side
    fb_state_t        state;
    fb_state_t        state_nxt;
    logic [FB_AW-1:0] clear_addr;
    logic             plot_ok;
    logic [FB_AW-1:0] plot_addr;
    logic             we;
    logic [FB_AW-1:0] waddr;
    logic [COL_W-1:0] wdata;

    // Pixel enable: half-rate strobe that also serves as the VGA pixel clock
    always_ff @(posedge Clock) begin
        if (Reset) pe <= 1'b0;
        else       pe <= ~pe;
    end

    // Horizontal / vertical scan counters, stepping once per pixel tick
    always_ff @(posedge Clock) begin
        if (Reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) v_cnt <= '0;
                else                 v_cnt <= v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Raw sync/visibility decode and the replicated read address
    always_comb begin
        hsync_raw = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
        vsync_raw = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
        vis       = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        rd_addr   = fb_addr(FB_AW'(v_cnt >> SCALE_LOG2), FB_AW'(h_cnt >> SCALE_LOG2));
    end

    fb_ram u_ram (
        .Clock (Clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // ---- stage p1: RAM word and matching sync/vis captured on the pixel tick
    // Sync and visibility flags enter the pipeline alongside the RAM read
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            vis_p1 <= 1'b0;
        end else if (pe) begin
            hs_p1  <= hsync_raw;
            vs_p1  <= vsync_raw;
            vis_p1 <= vis;
        end
    end

    // Pixel data stage; gated downstream so it needs no reset
    always_ff @(posedge Clock) begin
        if (pe) pix_p1 <= rd_data;
    end

    // ---- stage p2: output registers, colour blanked outside the visible area
    // Pin registers, two pixel ticks behind the scan counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hs_p2  <= 1'b1;
            vs_p2  <= 1'b1;
            vis_p2 <= 1'b0;
            rgb_p2 <= '0;
        end else if (pe) begin
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            vis_p2 <= vis_p1;
            rgb_p2 <= vis_p1 ? pix_p1 : '0;
        end
    end

    assign VGA_R       = col_r(rgb_p2);
    assign VGA_G       = col_g(rgb_p2);
    assign VGA_B       = col_b(rgb_p2);
    assign VGA_HS      = hs_p2;
    assign VGA_VS      = vs_p2;
    assign VGA_BLANK_N = vis_p2;
    assign VGA_CLK     = pe;

    // Plot address and bounds check
    always_comb begin
        plot_ok   = (x < X_LIMIT) && (y < Y_LIMIT);
        plot_addr = fb_addr(FB_AW'(y), FB_AW'(x));
    end

    // FSM state register and clear sweep address
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_CLEAR;
            clear_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) clear_addr <= clear_addr + 1'b1;
        end
    end

    // FSM next state: leave the clear sweep once the last location is written
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clear_addr == CLEAR_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // FSM outputs: the clear sweep owns the write port, plots are dropped meanwhile
    always_comb begin
        busy  = 1'b0;
        we    = 1'b0;
        waddr = plot_addr;
        wdata = colour;
        case (state)
            S_CLEAR: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = clear_addr;
                wdata = CLEAR_COLOUR;
            end
            S_RUN: begin
                we = writeEn && plot_ok;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Bench for vga_frame_buffer. Vertical timing is shortened (8 visible lines,
// 12-line frame) so several complete frames fit in a short run; horizontal
// timing is the full 800-tick line. A reference model of the scan and the
// stored image predicts every pin value two pixel ticks ahead.
module tb_vga_frame_buffer;
    import vga_pkg::*;

    localparam int TV_VIS  = 8;
    localparam int TV_FP   = 1;
    localparam int TV_SYNC = 2;
    localparam int TV_BP   = 1;
    localparam int HT      = 800;
    localparam int VT      = TV_VIS + TV_FP + TV_SYNC + TV_BP;
    localparam int FRAME   = HT * VT;
    localparam int END_CYC = 6 * FRAME + 8;
    localparam logic [15:0] RST_SIG = {1'b0, 1'b1, 1'b1, 1'b0, 12'h000};

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [11:0] colour = '0;
    logic        writeEn = 1'b0;
    logic        busy;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK;

    vga_frame_buffer #(
        .V_VIS (TV_VIS),
        .V_FP  (TV_FP),
        .V_SYNC(TV_SYNC),
        .V_BP  (TV_BP)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .busy       (busy),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_CLK    (VGA_CLK)
    );

    always #10 Clock = ~Clock;

    typedef struct {
        logic [15:0] sig;
        bit          chk_rgb;
        int          tick;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] model [0:FB_DEPTH-1];
    exp_t        sb [$];
    int          ncyc = 0;
    logic        rst_q = 1'b0;
    int          rgb_from = 32'h7fff_ffff;
    int          hs_low = 0;
    int          vs_low = 0;
    int          blank_hi = 0;

    // Expected {VGA_CLK, HS, VS, BLANK_N, RGB} for a given scan tick
    function automatic logic [15:0] exp_sig(input int tk);
        int h, v;
        logic hs, vs, bl;
        logic [11:0] px;
        h  = tk % HT;
        v  = (tk / HT) % VT;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= TV_VIS + TV_FP && v < TV_VIS + TV_FP + TV_SYNC);
        bl = (h < 640) && (v < TV_VIS);
        px = bl ? model[15'((v / 4) * 160 + h / 4)] : 12'h000;
        return {1'b0, hs, vs, bl, px};
    endfunction

    // Clock count since the last reset edge
    always @(posedge Clock) begin
        rst_q <= Reset;
        ncyc  <= Reset ? 0 : ncyc + 1;
    end

    // Scoreboard: push the prediction for the current tick, compare the one
    // that should be on the pins now (two ticks older)
    always @(negedge Clock) begin
        exp_t e;
        exp_t p;
        logic [15:0] obs;
        logic [15:0] ex;
        if (rst_q) begin
            sb.delete();
            e.sig = RST_SIG; e.chk_rgb = 1'b1; e.tick = -1;
            sb.push_back(e);
            sb.push_back(e);
        end
        if (ncyc % 2 == 0) begin
            e.tick    = ncyc / 2;
            e.chk_rgb = (e.tick >= rgb_from);
            e.sig     = exp_sig(e.tick);
            sb.push_back(e);
            if (sb.size() > 2) begin
                p   = sb.pop_front();
                obs = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
                ex  = p.sig;
                if (!p.chk_rgb) begin
                    obs[11:0] = '0;
                    ex[11:0]  = '0;
                end
                checks++;
                assert (obs === ex) else begin
                    errors++;
                    $error("FAIL scan tick=%0d pins=%h expected=%h", p.tick, obs, ex);
                end
                if (p.tick >= 2 * FRAME && p.tick < 3 * FRAME) begin
                    if (!VGA_HS)     hs_low++;
                    if (!VGA_VS)     vs_low++;
                    if (VGA_BLANK_N) blank_hi++;
                end
            end
        end
    end

    task automatic plot(input int px, input int py, input logic [11:0] c);
        x       = 8'(px);
        y       = 7'(py);
        colour  = c;
        writeEn = 1'b1;
        @(negedge Clock);
        writeEn = 1'b0;
        if (px < 160 && py < 120) model[15'(py * 160 + px)] = c;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < FB_DEPTH; i++) model[i] = 12'h000;

        // Reset for one clock, then let the clear run part way
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        check("busy_after_reset", 32'(busy), 32'd1);
        repeat (4999) @(negedge Clock);
        check("busy_mid_clear", 32'(busy), 32'd1);

        // Reset mid-clear: the sweep and the scan restart from zero
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 25000) begin
            if (n == 100) begin
                x = 8'd10; y = 7'd10; colour = 12'hf00; writeEn = 1'b1;
            end else if (n == 101) begin
                x = 8'd1; y = 7'd0; colour = 12'hf00; writeEn = 1'b1;
            end else begin
                writeEn = 1'b0;
            end
            @(negedge Clock);
            n++;
        end
        writeEn = 1'b0;
        check("clear_length", 32'(n), 32'd19200);
        check("plot_during_clear", 32'(dut.u_ram.mem[1610]), 32'h000);

        // Plots in the first frame after the clear; shown from the second frame
        plot(0, 0, 12'h2c3);
        plot(159, 0, 12'hfff);
        plot(5, 1, 12'habc);
        plot(159, 119, 12'hfff);
        plot(160, 0, 12'h0f0);
        plot(0, 120, 12'h00f);
        check("corner_store", 32'(dut.u_ram.mem[19199]), 32'hfff);
        check("row1_untouched", 32'(dut.u_ram.mem[160]), 32'h000);
        rgb_from = 2 * FRAME;

        for (int i = 0; i < 70000 && ncyc < END_CYC; i++) @(negedge Clock);
        check("scan_reached_end", 32'(ncyc >= END_CYC), 32'd1);
        @(negedge Clock);

        check("hsync_low_ticks", 32'(hs_low), 32'(96 * VT));
        check("vsync_low_ticks", 32'(vs_low), 32'(TV_SYNC * HT));
        check("blank_high_ticks", 32'(blank_hi), 32'(640 * TV_VIS));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
